// File: rtl/grf_wb_pkg.sv
// Shared types and constants for the register-file writeback controller.
package grf_wb_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned DATA_W     = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
      logic [DATA_W-1:0]     pc;
   } wb_result_t;

   function automatic logic [DATA_W-1:0] addr_mask(input logic [REG_ADDR_W-1:0] a);
      return {{(DATA_W-1){1'b0}}, 1'b1} << a;
   endfunction

endpackage

// File: rtl/grf_wb_ctrl_if.sv
// Bundle of issue, producer and register-file write-port signals.
// master is the controller's view; slave is the surrounding pipeline's view.
interface grf_wb_ctrl_if;
   import grf_wb_pkg::*;

   logic                  iss_valid;
   logic [REG_ADDR_W-1:0] iss_addr;

   logic                  p0_valid;
   logic [REG_ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0]     p0_data;
   logic [DATA_W-1:0]     p0_pc;

   logic                  p1_valid;
   logic                  p1_ready;
   logic [REG_ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0]     p1_data;
   logic [DATA_W-1:0]     p1_pc;

   logic                  WE;
   logic [REG_ADDR_W-1:0] A3;
   logic [DATA_W-1:0]     WD;
   logic [DATA_W-1:0]     WPC;
   logic [DATA_W-1:0]     busy;

   modport master (
      input  iss_valid, iss_addr,
      input  p0_valid, p0_addr, p0_data, p0_pc,
      input  p1_valid, p1_addr, p1_data, p1_pc,
      output p1_ready,
      output WE, A3, WD, WPC, busy
   );

   modport slave (
      output iss_valid, iss_addr,
      output p0_valid, p0_addr, p0_data, p0_pc,
      output p1_valid, p1_addr, p1_data, p1_pc,
      input  p1_ready,
      input  WE, A3, WD, WPC, busy
   );

endinterface

// File: rtl/grf_wb_ctrl_wb_fifo.sv
// Small power-of-two FIFO holding long-latency results until the write port is free.
module wb_fifo
   import grf_wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  wb_result_t din,
   output logic       full,
   output logic       empty,
   output wb_result_t head
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   wb_result_t            mem_q [DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]       count_q, count_d;
   logic                  do_push, do_pop;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/grf_wb_ctrl.sv
// Register-file writeback initiator: arbitrates ALU and buffered long-latency results
// onto one write port and tracks pending writes. Optional trace under GRF_WB_TRACE_EN.
module grf_wb_ctrl
   import grf_wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   grf_wb_ctrl_if.master wb
);

   wb_result_t        p0_res, p1_res, head, sel, out_q;
   logic              full, empty, push, pop;
   logic              sel_valid, we_d, we_q;
   logic [DATA_W-1:0] busy_d, busy_q;

   assign p0_res = '{addr: wb.p0_addr, data: wb.p0_data, pc: wb.p0_pc};
   assign p1_res = '{addr: wb.p1_addr, data: wb.p1_data, pc: wb.p1_pc};

   assign wb.p1_ready = !full;
   assign push        = wb.p1_valid && !full;
   assign pop         = !wb.p0_valid && !empty;

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (p1_res),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   always_comb begin
      sel_valid = wb.p0_valid || !empty;
      sel       = wb.p0_valid ? p0_res : head;
      we_d      = sel_valid && (sel.addr != REG_ZERO);

      // Clear first so a same-cycle issue to the same register stays pending.
      busy_d = busy_q;
      if (sel_valid) busy_d = busy_d & ~addr_mask(sel.addr);
      if (wb.iss_valid && (wb.iss_addr != REG_ZERO)) busy_d = busy_d | addr_mask(wb.iss_addr);
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         we_q   <= 1'b0;
         out_q  <= '0;
         busy_q <= '0;
      end else begin
         we_q   <= we_d;
         busy_q <= busy_d;
         if (we_d) out_q <= sel;
      end
   end

   // Gate with reset so a write registered just before reset never reaches the file.
   assign wb.WE   = we_q && !reset;
   assign wb.A3   = out_q.addr;
   assign wb.WD   = out_q.data;
   assign wb.WPC  = out_q.pc;
   assign wb.busy = busy_q;

`ifdef GRF_WB_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset && we_d) begin
         $display("@%08h: $%0d <= %08h", sel.pc, sel.addr, sel.data);
      end
   end
`else
   // Trace disabled: WPC remains on the port for external tracing.
`endif

endmodule

// File: tb/tb_grf_wb_ctrl.sv
// Directed bench for grf_wb_ctrl: vector table plus FIFO-full and mid-stream reset sequences.
module tb_grf_wb_ctrl;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_fail;

   grf_wb_ctrl_if wb ();

   grf_wb_ctrl #(
      .DEPTH (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .wb    (wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iss_v;
      logic [4:0]  iss_a;
      logic        p0_v;
      logic [4:0]  p0_a;
      logic [31:0] p0_d;
      logic [31:0] p0_pc;
      logic        p1_v;
      logic [4:0]  p1_a;
      logic [31:0] p1_d;
      logic [31:0] p1_pc;
      logic        we;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic [31:0] wpc;
      logic [31:0] busy;
      logic        rdy;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb.iss_valid = 1'b0; wb.iss_addr = '0;
      wb.p0_valid  = 1'b0; wb.p0_addr  = '0; wb.p0_data = '0; wb.p0_pc = '0;
      wb.p1_valid  = 1'b0; wb.p1_addr  = '0; wb.p1_data = '0; wb.p1_pc = '0;
   endtask

   task automatic set_p0(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] pc);
      wb.p0_valid = v; wb.p0_addr = a; wb.p0_data = d; wb.p0_pc = pc;
   endtask

   task automatic set_p1(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] pc);
      wb.p1_valid = v; wb.p1_addr = a; wb.p1_data = d; wb.p1_pc = pc;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_cmp  = 0;
      n_fail = 0;

      vecs[0] = '{1'b1, 5'd8, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0,
                  1'b0, 5'd0, 32'h0, 32'h0, 32'h0000_0100, 1'b1};
      vecs[1] = '{1'b0, 5'd0, 1'b1, 5'd8, 32'h1234, 32'h3000, 1'b0, 5'd0, 32'h0, 32'h0,
                  1'b1, 5'd8, 32'h1234, 32'h3000, 32'h0, 1'b1};
      vecs[2] = '{1'b1, 5'd3, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h3004, 1'b0, 5'd0, 32'h0, 32'h0,
                  1'b0, 5'd0, 32'h0, 32'h0, 32'h0000_0008, 1'b1};
      vecs[3] = '{1'b1, 5'd5, 1'b1, 5'd5, 32'hAAAA_5555, 32'h3008, 1'b0, 5'd0, 32'h0, 32'h0,
                  1'b1, 5'd5, 32'hAAAA_5555, 32'h3008, 32'h0000_0028, 1'b1};
      vecs[4] = '{1'b0, 5'd0, 1'b1, 5'd3, 32'h33, 32'h300C, 1'b0, 5'd0, 32'h0, 32'h0,
                  1'b1, 5'd3, 32'h33, 32'h300C, 32'h0000_0020, 1'b1};
      vecs[5] = '{1'b0, 5'd0, 1'b1, 5'd5, 32'h55, 32'h3010, 1'b1, 5'd7, 32'h77, 32'h4000,
                  1'b1, 5'd5, 32'h55, 32'h3010, 32'h0, 1'b1};
      vecs[6] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0,
                  1'b1, 5'd7, 32'h77, 32'h4000, 32'h0, 1'b1};
      vecs[7] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0,
                  1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1};

      // Power-on reset.
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      chk("rst_we",   32'(wb.WE), 32'(1'b0));
      chk("rst_a3",   32'(wb.A3), 32'h0);
      chk("rst_wd",   wb.WD, 32'h0);
      chk("rst_wpc",  wb.WPC, 32'h0);
      chk("rst_busy", wb.busy, 32'h0);
      chk("rst_rdy",  32'(wb.p1_ready), 32'(1'b1));

      // Table: issue/scoreboard, reg-0 writes, set-wins, p0-before-p1 ordering.
      for (int i = 0; i < 8; i++) begin
         wb.iss_valid = vecs[i].iss_v;
         wb.iss_addr  = vecs[i].iss_a;
         set_p0(vecs[i].p0_v, vecs[i].p0_a, vecs[i].p0_d, vecs[i].p0_pc);
         set_p1(vecs[i].p1_v, vecs[i].p1_a, vecs[i].p1_d, vecs[i].p1_pc);
         step();
         idle_inputs();
         chk($sformatf("v%0d_we", i),   32'(wb.WE), 32'(vecs[i].we));
         chk($sformatf("v%0d_busy", i), wb.busy, vecs[i].busy);
         chk($sformatf("v%0d_rdy", i),  32'(wb.p1_ready), 32'(vecs[i].rdy));
         if (vecs[i].we) begin
            chk($sformatf("v%0d_a3", i),  32'(wb.A3), 32'(vecs[i].a3));
            chk($sformatf("v%0d_wd", i),  wb.WD, vecs[i].wd);
            chk($sformatf("v%0d_wpc", i), wb.WPC, vecs[i].wpc);
         end
      end

      // Fill FIFO while p0 holds the port, then drain in order.
      for (int i = 0; i < 4; i++) begin
         set_p0(1'b1, 5'd1, 32'(i), 32'h5000 + 32'(4 * i));
         set_p1(1'b1, 5'(10 + i), 32'hA0 + 32'(i), 32'h6000 + 32'(4 * i));
         step();
         chk($sformatf("fill%0d_we", i), 32'(wb.WE), 32'(1'b1));
         chk($sformatf("fill%0d_a3", i), 32'(wb.A3), 32'd1);
         chk($sformatf("fill%0d_rdy", i), 32'(wb.p1_ready), (i < 3) ? 32'd1 : 32'd0);
      end
      set_p0(1'b1, 5'd1, 32'h99, 32'h5010);
      set_p1(1'b1, 5'd14, 32'hEE, 32'h6010);
      step();
      chk("full_hold_rdy", 32'(wb.p1_ready), 32'd0);
      chk("full_hold_wd",  wb.WD, 32'h99);
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("drain%0d_we", i),  32'(wb.WE), 32'(1'b1));
         chk($sformatf("drain%0d_a3", i),  32'(wb.A3), 32'(10 + i));
         chk($sformatf("drain%0d_wd", i),  wb.WD, 32'hA0 + 32'(i));
         chk($sformatf("drain%0d_wpc", i), wb.WPC, 32'h6000 + 32'(4 * i));
         chk($sformatf("drain%0d_rdy", i), 32'(wb.p1_ready), 32'd1);
      end
      step();
      chk("drain_done_we", 32'(wb.WE), 32'(1'b0));

      // Reset mid-stream with three buffered entries and a pending bit.
      for (int i = 0; i < 3; i++) begin
         wb.iss_valid = (i == 0);
         wb.iss_addr  = 5'd9;
         set_p0(1'b1, 5'd1, 32'h10 + 32'(i), 32'h7000 + 32'(4 * i));
         set_p1(1'b1, 5'(20 + i), 32'hC0 + 32'(i), 32'h8000 + 32'(4 * i));
         step();
      end
      chk("pre_rst_busy", wb.busy, 32'h0000_0200);
      idle_inputs();
      reset = 1'b1;
      #1;
      chk("in_rst_we", 32'(wb.WE), 32'(1'b0));
      step();
      reset = 1'b0;
      chk("post_rst_we",   32'(wb.WE), 32'(1'b0));
      chk("post_rst_busy", wb.busy, 32'h0);
      chk("post_rst_rdy",  32'(wb.p1_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("stale%0d_we", i), 32'(wb.WE), 32'(1'b0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
